// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, low WIDTH bits of A*B,
// one multiplier bit per clock, start/busy/done handshake.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request, sampled only while busy=0 (IDLE or DONE)
//   A, B    multiplicand / multiplier, sampled with an accepted start
//   busy    operation in progress (registered)
//   done    one-cycle completion pulse (registered)
//   result  low WIDTH bits of A*B, held until the next completion
//
// Build option: define SEQ_MUL_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are all zero (minimum one iteration).
// Results are the same either way; only latency changes.

module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int         CW   = 6;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] mplier_sh;
  logic             last_iter;

  // Partial product for this iteration; carry out of WIDTH is dropped.
  assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_sh = mplier_q >> 1;

  always_comb begin
    last_iter = (count_q == LAST);
`ifdef SEQ_MUL_EARLY_TERM_EN
    // No set bits left after this shift: further iterations add nothing.
    last_iter = last_iter || (mplier_sh == '0);
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // A start in DONE is accepted like in IDLE: back-to-back ops.
        if (start) begin
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        count_d  = count_q + CW'(1);
        if (last_iter) begin
          result_d = acc_sum;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          busy_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier.
// Stimulus pushes expected product and latency; a monitor checks on done.

module tb_seq_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [31:0] res;
    int          acc_edge;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] prev_result = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_mul(input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic int model_lat(input logic [31:0] b);
    int n;
    n = 32;
`ifdef SEQ_MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++)
      if (b[i]) n = i + 1;
`endif
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // Monitor: pops expectations on done, checks handshake every cycle.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (!reset) begin
      check("busy_and_done", 32'(busy & done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("latency", 32'(cyc - e.acc_edge), 32'(e.lat));
        end
      end else begin
        check("result_hold", result, prev_result);
      end
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc_edge);
      check("busy", 32'(busy), 32'(exp_busy));
      prev_result = result;
    end
  end

  // One cycle: while busy, throw junk starts that must be ignored.
  task automatic step();
    @(negedge clk);
    #1;
    if (busy) begin
      start = 1'($urandom_range(0, 1));
      A     = $urandom;
      B     = $urandom;
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input int gap);
    int   g;
    exp_t e;
    for (int i = 0; i < gap; i++) step();
    g = 0;
    while (busy && g < 100) begin
      step();
      g++;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    A          = a;
    B          = b;
    start      = 1'b1;
    e.res      = model_mul(a, b);
    e.acc_edge = cyc + 1;
    e.lat      = model_lat(b);
    sb.push_back(e);
    step();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 200) begin
      step();
      g++;
    end
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc0;
    int g;
    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    #1 reset = 1'b0;

    issue(32'd100, 32'd5, 0);
    drain();
    check("dir_100x5", result, 32'h0000_01F4);
    issue(32'hFFFF_FFFE, 32'h0000_FFFF, 1);
    drain();
    check("dir_big", result, 32'hFFFE_0002);
    issue(32'hFFFF_FFFB, 32'd7, 0);
    drain();
    check("dir_neg", result, 32'hFFFF_FFDD);
    issue(32'd3, 32'd4, 2);
    issue(32'hDEAD_BEEF, 32'd0, 0);
    issue(32'h1234_5678, 32'h8000_0000, 0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(32'd0, 32'hFFFF_FFFF, 0);
    drain();

    // Reset between E10 and E11 of a long operation.
    issue(32'd100, 32'h8000_0005, 1);
    acc0 = sb[0].acc_edge;
    g = 0;
    while (cyc < acc0 + 10 && g < 50) begin
      step();
      g++;
    end
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    sb.delete();
    prev_result = '0;
    start = 1'b0;
    #1 reset = 1'b0;
    issue(32'd6, 32'd7, 0);
    drain();
    check("post_rst_6x7", result, 32'd42);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          gap;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = rb >> $urandom_range(0, 31);
        1: ra = ra >> $urandom_range(0, 31);
        default: ;
      endcase
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      issue(ra, rb, gap);
    end
    drain();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
